conv_pool_ctrl: RTL and testbench

Sequencer for one 3x3 convolution + 2x2 max-pool layer over a single-channel feature map held in an external synchronous-read RAM. It walks pool windows in raster order and fetches the 9 window pixels for each of the 4 conv positions. It drives the shared vec_mult_9 datapath, feeds the 4 conv results to max_4, applies optional ReLU, and emits one pooled value per valid/ready handshake. It sits between the feature-map buffer and the next layer's input buffer.

---
 rtl/conv_pool_ctrl_pkg.sv | 14 +
 rtl/conv_addr_gen.sv | 35 +++
 rtl/max_4.sv | 18 +
 rtl/vec_mult_9.sv | 23 ++
 rtl/conv_pool_ctrl.sv | 144 ++++++++++++++
 tb/tb_conv_pool_ctrl.sv | 224 ++++++++++++++++++++++
 6 files changed

// File: rtl/conv_pool_ctrl_pkg.sv
// Shared DSP word sizes and the sequencer state encoding for the conv + max-pool layer.
package conv_pool_ctrl_pkg;
    localparam int DATSIZE = 16;
    localparam int PARSIZE = 16;
    localparam int FPSHIFT = 14;

    typedef enum logic [2:0] {
        CTRL_IDLE  = 3'd0,
        CTRL_FETCH = 3'd1,
        CTRL_MAC   = 3'd2,
        CTRL_OUT   = 3'd3,
        CTRL_DONE  = 3'd4
    } ctrl_state_e;
endpackage

// File: rtl/conv_addr_gen.sv
// Maps (pool row, pool col, quad, tap) to the linear RAM address of one window pixel.
module conv_addr_gen #(
    parameter int IMG_W  = 28,
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] i_pr,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [1:0]        i_q,
    input  logic [3:0]        i_k,
    output logic [ADDR_W-1:0] o_addr
);
    localparam logic [ADDR_W-1:0] W_IMG = ADDR_W'(IMG_W);

    logic [1:0]        w_dr, w_dc;
    logic [ADDR_W-1:0] w_row, w_col;

    always_comb begin
        w_dr = 2'd0;
        w_dc = 2'd0;
        case (i_k)
            4'd1: w_dc = 2'd1;
            4'd2: w_dc = 2'd2;
            4'd3: w_dr = 2'd1;
            4'd4: begin w_dr = 2'd1; w_dc = 2'd1; end
            4'd5: begin w_dr = 2'd1; w_dc = 2'd2; end
            4'd6: w_dr = 2'd2;
            4'd7: begin w_dr = 2'd2; w_dc = 2'd1; end
            4'd8: begin w_dr = 2'd2; w_dc = 2'd2; end
            default: ;
        endcase
        w_row  = (i_pr << 1) + ADDR_W'(i_q[1]) + ADDR_W'(w_dr);
        w_col  = (i_pc << 1) + ADDR_W'(i_q[0]) + ADDR_W'(w_dc);
        o_addr = w_row * W_IMG + w_col;
    end
endmodule

// File: rtl/max_4.sv
// Signed maximum of four data words.
module max_4
    import conv_pool_ctrl_pkg::*;
(
    input  logic signed [DATSIZE-1:0] i_a,
    input  logic signed [DATSIZE-1:0] i_b,
    input  logic signed [DATSIZE-1:0] i_c,
    input  logic signed [DATSIZE-1:0] i_d,
    output logic signed [DATSIZE-1:0] o_max
);
    logic signed [DATSIZE-1:0] w_ab, w_cd;

    always_comb begin
        w_ab  = (i_a > i_b) ? i_a : i_b;
        w_cd  = (i_c > i_d) ? i_c : i_d;
        o_max = (w_ab > w_cd) ? w_ab : w_cd;
    end
endmodule

// File: rtl/vec_mult_9.sv
// 9-tap signed dot product, scaled by FPSHIFT and truncated to a data word.
module vec_mult_9
    import conv_pool_ctrl_pkg::*;
(
    input  logic [9*DATSIZE-1:0]        i_data,
    input  logic [9*PARSIZE-1:0]        i_coef,
    output logic signed [DATSIZE-1:0]   o_result
);
    localparam int ACC_W = DATSIZE + PARSIZE + 4;

    logic signed [DATSIZE+PARSIZE-1:0] w_prod;
    logic signed [ACC_W-1:0]           w_acc;

    always_comb begin
        w_prod = '0;
        w_acc  = '0;
        for (int i = 0; i < 9; i++) begin
            w_prod = $signed(i_data[i*DATSIZE +: DATSIZE]) * $signed(i_coef[i*PARSIZE +: PARSIZE]);
            w_acc  = w_acc + ACC_W'(w_prod);
        end
        o_result = DATSIZE'(w_acc >>> FPSHIFT);
    end
endmodule

// File: rtl/conv_pool_ctrl.sv
// Sequencer for one 3x3 conv + 2x2 max-pool layer: fetches windows, runs the shared MAC,
// pools four conv results and hands each pooled value downstream over valid/ready.
module conv_pool_ctrl
    import conv_pool_ctrl_pkg::*;
#(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10,
    parameter int RELU   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [9*PARSIZE-1:0]      weights,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_en,
    input  logic signed [DATSIZE-1:0] rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [DATSIZE-1:0] out_data,
    output logic [ADDR_W-1:0]         out_idx
);
    localparam int POOL_W = (IMG_W - 2) / 2;
    localparam int POOL_H = (IMG_H - 2) / 2;
    localparam logic [ADDR_W-1:0] PC_LAST  = ADDR_W'(POOL_W - 1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(POOL_W * POOL_H - 1);

    function automatic logic signed [DATSIZE-1:0] relu_fn(input logic signed [DATSIZE-1:0] x);
        return (RELU != 0 && x < 0) ? '0 : x;
    endfunction

    ctrl_state_e               r_state, w_next;
    logic [9*PARSIZE-1:0]      r_weights;
    logic signed [DATSIZE-1:0] r_win [0:8];
    logic signed [DATSIZE-1:0] r_conv [0:2];
    logic [3:0]                r_k;
    logic [1:0]                r_q;
    logic [ADDR_W-1:0]         r_pr, r_pc, r_pidx;
    logic [9*DATSIZE-1:0]      w_win;
    logic signed [DATSIZE-1:0] w_mac, w_max;
    logic                      w_last;

    always_comb begin
        for (int i = 0; i < 9; i++) w_win[i*DATSIZE +: DATSIZE] = r_win[i];
    end

    conv_addr_gen #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) u_addr (
        .i_pr(r_pr), .i_pc(r_pc), .i_q(r_q), .i_k(r_k), .o_addr(rd_addr)
    );

    vec_mult_9 u_mac (.i_data(w_win), .i_coef(r_weights), .o_result(w_mac));

    // The fourth conv result is pooled straight from the MAC so the output lands one cycle earlier.
    max_4 u_max (.i_a(r_conv[0]), .i_b(r_conv[1]), .i_c(r_conv[2]), .i_d(w_mac), .o_max(w_max));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= CTRL_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        rd_en  = 1'b0;
        w_last = (r_pidx == IDX_LAST);
        case (r_state)
            CTRL_IDLE:  if (start) w_next = CTRL_FETCH;
            CTRL_FETCH: begin
                busy  = 1'b1;
                rd_en = (r_k < 4'd9);
                if (r_k == 4'd9) w_next = CTRL_MAC;
            end
            CTRL_MAC: begin
                busy   = 1'b1;
                w_next = (r_q == 2'd3) ? CTRL_OUT : CTRL_FETCH;
            end
            CTRL_OUT: begin
                busy = 1'b1;
                if (out_ready) w_next = w_last ? CTRL_DONE : CTRL_FETCH;
            end
            CTRL_DONE: begin
                done   = 1'b1;
                w_next = CTRL_IDLE;
            end
            default: w_next = CTRL_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_weights <= '0;
            for (int i = 0; i < 9; i++) r_win[i] <= '0;
            for (int i = 0; i < 3; i++) r_conv[i] <= '0;
            r_k       <= '0;
            r_q       <= '0;
            r_pr      <= '0;
            r_pc      <= '0;
            r_pidx    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
        end else begin
            case (r_state)
                CTRL_IDLE: if (start) begin
                    r_weights <= weights;
                    r_k       <= '0;
                    r_q       <= '0;
                    r_pr      <= '0;
                    r_pc      <= '0;
                    r_pidx    <= '0;
                end
                CTRL_FETCH: begin
                    // RAM data lags the strobe by one cycle, so tap k-1 arrives on cycle k.
                    if (r_k != 4'd0) r_win[r_k - 4'd1] <= rd_data;
                    r_k <= (r_k == 4'd9) ? 4'd0 : r_k + 4'd1;
                end
                CTRL_MAC: begin
                    if (r_q != 2'd3) begin
                        r_conv[r_q] <= w_mac;
                    end else begin
                        out_data  <= relu_fn(w_max);
                        out_idx   <= r_pidx;
                        out_valid <= 1'b1;
                    end
                    r_q <= r_q + 2'd1;
                end
                CTRL_OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    r_pidx    <= r_pidx + 1'b1;
                    if (r_pc == PC_LAST) begin
                        r_pc <= '0;
                        r_pr <= r_pr + 1'b1;
                    end else begin
                        r_pc <= r_pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_pool_ctrl.sv
// Randomised bench for conv_pool_ctrl on a 6x6 map; RELU=1 and RELU=0 instances run side by side.
module tb_conv_pool_ctrl;
    import conv_pool_ctrl_pkg::*;

    localparam int IW = 6;
    localparam int IH = 6;
    localparam int AW = 10;
    localparam int PW = (IW - 2) / 2;
    localparam int PH = (IH - 2) / 2;
    localparam int NP = PW * PH;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 out_ready = 1'b1;
    logic [9*PARSIZE-1:0] weights = '0;

    logic                 busy1, done1, rd_en1, vld1, busy0, done0, rd_en0, vld0;
    logic [AW-1:0]        addr1, idx1, addr0, idx0;
    logic signed [15:0]   rdd1 = '0, rdd0 = '0, dat1, dat0;

    logic signed [15:0]   mem [0:1023];
    logic signed [15:0]   wts [0:8];
    int                   cyc = 0;
    int                   n_chk = 0;
    int                   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rd_en1) rdd1 <= mem[addr1];
        if (rd_en0) rdd0 <= mem[addr0];
    end

    conv_pool_ctrl #(.IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .RELU(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .weights(weights),
        .busy(busy1), .done(done1), .rd_addr(addr1), .rd_en(rd_en1), .rd_data(rdd1),
        .out_valid(vld1), .out_ready(out_ready), .out_data(dat1), .out_idx(idx1)
    );

    conv_pool_ctrl #(.IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .RELU(0)) u_dut_raw (
        .clk(clk), .rst_n(rst_n), .start(start), .weights(weights),
        .busy(busy0), .done(done0), .rd_addr(addr0), .rd_en(rd_en0), .rd_data(rdd0),
        .out_valid(vld0), .out_ready(out_ready), .out_data(dat0), .out_idx(idx0)
    );

    task automatic check_eq(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One output pixel of the 3x3 convolution with top-left (r,c), straight from the definition.
    function automatic logic signed [15:0] conv_ref(input int r, input int c);
        longint acc = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                acc += longint'(mem[(r + dr) * IW + c + dc]) * longint'(wts[dr * 3 + dc]);
        return 16'(acc >>> FPSHIFT);
    endfunction

    // bp: 0 = ready always high, 1 = random ready, 2 = ready low for the first 5 OUT cycles.
    task automatic run_frame(input int bp, input int abort_at);
        logic signed [15:0] exp_relu [$];
        logic signed [15:0] exp_raw [$];
        int                 exp_addr [$];
        logic signed [15:0] m, v, hd;
        logic [AW-1:0]      hi;
        int                 t0, c, n, last_x;
        bit                 fin, held;

        for (int pr = 0; pr < PH; pr++)
            for (int pc = 0; pc < PW; pc++) begin
                m = conv_ref(2 * pr, 2 * pc);
                for (int q = 1; q < 4; q++) begin
                    v = conv_ref(2 * pr + q / 2, 2 * pc + q % 2);
                    if (v > m) m = v;
                end
                exp_raw.push_back(m);
                exp_relu.push_back((m < 0) ? 16'sd0 : m);
                for (int q = 0; q < 4; q++)
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            exp_addr.push_back((2 * pr + q / 2 + dr) * IW + 2 * pc + q % 2 + dc);
            end

        for (int i = 0; i < 9; i++) weights[i*PARSIZE +: PARSIZE] = wts[i];
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        n = 0; last_x = -10; fin = 0; held = 0; hd = '0; hi = '0;

        for (int it = 0; it < 3000 && !fin; it++) begin
            c = cyc - t0;
            weights = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
            start = (c == 20);
            case (bp)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !(c >= 45 && c <= 49);
            endcase

            if (abort_at != 0 && c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("abort_busy", busy1, 0);
                check_eq("abort_valid", vld1, 0);
                check_eq("abort_data", dat1, 0);
                check_eq("abort_rd_en", rd_en1, 0);
                check_eq("abort_done", done1, 0);
                @(negedge clk);
                rst_n = 1'b1;
                start = 1'b0;
                @(negedge clk);
                return;
            end

            if (c == 1) check_eq("busy_after_start", busy1, 1);

            if (rd_en1) begin
                if (exp_addr.size() == 0) check_eq("extra_read", 1, 0);
                else begin
                    check_eq("rd_addr", addr1, exp_addr[0]);
                    check_eq("rd_addr_raw", addr0, exp_addr[0]);
                    void'(exp_addr.pop_front());
                end
            end

            if (held) begin
                check_eq("hold_valid", vld1, 1);
                check_eq("hold_data", dat1, hd);
                check_eq("hold_idx", idx1, hi);
            end else if (vld1 && (bp == 0 || n == 0)) begin
                check_eq("valid_time", c, 45 * (n + 1));
            end
            if (vld1) check_eq("rd_in_out", rd_en1, 0);

            if (vld1 && out_ready) begin
                if (n < NP) begin
                    check_eq("out_data", dat1, exp_relu[n]);
                    check_eq("out_data_raw", dat0, exp_raw[n]);
                    check_eq("out_idx", idx1, n);
                    check_eq("valid_raw", vld0, 1);
                    if (bp == 2 && n == 0) check_eq("bp_xfer_time", c, 50);
                end else begin
                    check_eq("extra_output", n, NP - 1);
                end
                n++;
                last_x = c;
            end
            held = vld1 && !out_ready;
            hd = dat1;
            hi = idx1;

            if (done1) begin
                check_eq("done_after_xfer", c, last_x + 1);
                if (bp == 0) check_eq("done_time", c, 45 * NP + 1);
                check_eq("done_busy", busy1, 0);
                check_eq("done_count", n, NP);
                check_eq("done_raw", done0, 1);
                fin = 1;
            end
            @(negedge clk);
        end
        if (!fin) check_eq("frame_timeout", 0, 1);
        check_eq("reads_left", exp_addr.size(), 0);
        out_ready = 1'b1;
    endtask

    task automatic set_ramp();
        for (int i = 0; i < IW * IH; i++) mem[i] = 16'(i);
    endtask

    task automatic set_center(input logic signed [15:0] w);
        for (int i = 0; i < 9; i++) wts[i] = '0;
        wts[4] = w;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy1, 0);
        check_eq("rst_done", done1, 0);
        check_eq("rst_rd_en", rd_en1, 0);
        check_eq("rst_valid", vld1, 0);
        check_eq("rst_data", dat1, 0);
        check_eq("rst_idx", idx1, 0);
        check_eq("rst_addr", addr1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        set_ramp();
        set_center(16'sd16384);
        run_frame(0, 0);

        set_center(-16'sd16384);
        run_frame(0, 0);

        for (int i = 0; i < IW * IH; i++) mem[i] = 16'sd1;
        for (int i = 0; i < 9; i++) wts[i] = 16'sd16384;
        run_frame(0, 0);

        set_ramp();
        set_center(16'sd16384);
        run_frame(2, 0);

        run_frame(0, 60);
        run_frame(0, 0);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < IW * IH; i++) mem[i] = 16'($urandom());
            for (int i = 0; i < 9; i++) wts[i] = 16'($urandom());
            run_frame(1, 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
